// File: rtl/dsp_slice_arbiter.sv
// Round-robin arbiter sharing one pipelined DSP48A1 slice among NREQ requesters,
// with burst locking, a CE-gated tag pipeline and stall-on-backpressure.
module dsp_slice_arbiter #(
  parameter int NREQ  = 4,
  parameter int A_W   = 18,
  parameter int B_W   = 18,
  parameter int P_W   = 48,
  parameter int OPM_W = 8,
  parameter int LAT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_last,
  input  logic [NREQ*A_W-1:0]       req_a,
  input  logic [NREQ*B_W-1:0]       req_b,
  input  logic [NREQ*OPM_W-1:0]     req_opmode,
  output logic [A_W-1:0]            dsp_a,
  output logic [B_W-1:0]            dsp_b,
  output logic [OPM_W-1:0]          dsp_opmode,
  output logic                      dsp_ce,
  input  logic [P_W-1:0]            dsp_p,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [P_W-1:0]            rsp_p,
  output logic                      busy
);

  localparam int ID_W = $clog2(NREQ);

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] lock_id_q, lock_id_d;

  logic [ID_W-1:0] grant;
  logic            grant_vld;
  logic            issue;
  int              scan_idx;
  logic [ID_W-1:0] scan_id;

  logic [LAT-1:0]  tag_vld_q, tag_vld_d;
  logic [LAT-1:0]  tag_last_q, tag_last_d;
  logic [ID_W-1:0] tag_id_q [LAT];
  logic [ID_W-1:0] tag_id_d [LAT];

  // Only the last beat of a burst carries a result worth returning.
  assign rsp_valid = tag_vld_q[LAT-1] && tag_last_q[LAT-1];
  assign rsp_id    = tag_id_q[LAT-1];
  assign rsp_p     = dsp_p;
  assign dsp_ce    = !(rsp_valid && !rsp_ready);
  assign busy      = (state_q == LOCK) || (|tag_vld_q);
  assign issue     = |(req_valid & req_ready);

  assign dsp_a      = req_a[grant*A_W +: A_W];
  assign dsp_b      = req_b[grant*B_W +: B_W];
  assign dsp_opmode = req_opmode[grant*OPM_W +: OPM_W];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    if (issue) begin
      rr_ptr_d = (grant == ID_W'(NREQ - 1)) ? '0 : grant + 1'b1;
      if (req_last[grant]) begin
        state_d = ARB;
      end else begin
        state_d   = LOCK;
        lock_id_d = grant;
      end
    end
  end

  // Output logic: descending scan so the requester closest to rr_ptr wins.
  always_comb begin
    grant     = lock_id_q;
    grant_vld = 1'b0;
    scan_idx  = 0;
    scan_id   = '0;
    if (state_q == LOCK) begin
      grant_vld = 1'b1;
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        scan_idx = int'(rr_ptr_q) + k;
        if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
        scan_id = ID_W'(scan_idx);
        if (req_valid[scan_id]) begin
          grant     = scan_id;
          grant_vld = 1'b1;
        end
      end
    end
    req_ready = '0;
    if (grant_vld && dsp_ce && !rst) req_ready[grant] = 1'b1;
  end

  // Tag pipeline advances in lockstep with the slice registers.
  always_comb begin
    tag_vld_d  = tag_vld_q;
    tag_last_d = tag_last_q;
    tag_id_d   = tag_id_q;
    if (dsp_ce) begin
      tag_vld_d[0]  = issue;
      tag_last_d[0] = req_last[grant];
      tag_id_d[0]   = grant;
      for (int s = 1; s < LAT; s++) begin
        tag_vld_d[s]  = tag_vld_q[s-1];
        tag_last_d[s] = tag_last_q[s-1];
        tag_id_d[s]   = tag_id_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_q  <= '0;
      tag_last_q <= '0;
      for (int s = 0; s < LAT; s++) tag_id_q[s] <= '0;
    end else begin
      tag_vld_q  <= tag_vld_d;
      tag_last_q <= tag_last_d;
      for (int s = 0; s < LAT; s++) tag_id_q[s] <= tag_id_d[s];
    end
  end

endmodule

// File: tb/tb_dsp_slice_arbiter.sv
// Directed bench for dsp_slice_arbiter: behavioural slice model plus a
// response scoreboard filled in expected issue order.
module tb_dsp_slice_arbiter;

  localparam int NREQ  = 4;
  localparam int A_W   = 18;
  localparam int B_W   = 18;
  localparam int P_W   = 48;
  localparam int OPM_W = 8;
  localparam int LAT   = 4;
  localparam logic [7:0] OPM_MULT = 8'h01;
  localparam logic [7:0] OPM_ACC  = 8'h09;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*A_W-1:0]   req_a;
  logic [NREQ*B_W-1:0]   req_b;
  logic [NREQ*OPM_W-1:0] req_opmode;
  logic [A_W-1:0]        dsp_a;
  logic [B_W-1:0]        dsp_b;
  logic [OPM_W-1:0]      dsp_opmode;
  logic                  dsp_ce;
  logic [P_W-1:0]        dsp_p;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [P_W-1:0]        rsp_p;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]     id;
    logic [P_W-1:0] p;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  dsp_slice_arbiter #(
    .NREQ(NREQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .OPM_W(OPM_W), .LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_a(req_a), .req_b(req_b), .req_opmode(req_opmode),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
    .dsp_p(dsp_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .busy(busy)
  );

  // Slice model: LAT-1 multiplier stages then the P register; all gated by CE.
  logic [P_W-1:0] s_prod [LAT-1];
  logic           s_acc  [LAT-1];
  logic [LAT-2:0] s_vld = '0;
  logic [P_W-1:0] s_p;
  assign dsp_p = s_p;

  always @(posedge clk) begin
    if (dsp_ce) begin
      s_prod[0] <= P_W'(dsp_a) * P_W'(dsp_b);
      s_acc[0]  <= (dsp_opmode == OPM_ACC);
      s_vld[0]  <= |(req_valid & req_ready);
      for (int i = 1; i < LAT - 1; i++) begin
        s_prod[i] <= s_prod[i-1];
        s_acc[i]  <= s_acc[i-1];
        s_vld[i]  <= s_vld[i-1];
      end
      if (s_vld[LAT-2]) s_p <= s_acc[LAT-2] ? s_p + s_prod[LAT-2] : s_prod[LAT-2];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: one line per accepted response.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      chk("rsp_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        $display("rsp id=%0d p=%0d (want id=%0d p=%0d)", rsp_id, rsp_p, mon_e.id, mon_e.p);
        chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
        chk("rsp_p", 64'(rsp_p), 64'(mon_e.p));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input int a, input int b, input logic [7:0] opm,
                        input logic last);
    req_a[i*A_W +: A_W]          = A_W'(a);
    req_b[i*B_W +: B_W]          = B_W'(b);
    req_opmode[i*OPM_W +: OPM_W] = opm;
    req_last[i]                  = last;
    req_valid[i]                 = 1'b1;
  endtask

  task automatic clr(input int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic expect_rsp(input int id, input int p);
    exp_t e;
    e.id = 2'(id);
    e.p  = P_W'(p);
    sb.push_back(e);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst        = 1'b1;
    req_last   = '0;
    req_a      = '0;
    req_b      = '0;
    req_opmode = '0;
    rsp_ready  = 1'b1;
    req_valid  = 4'b0010;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dsp_ce", 64'(dsp_ce), 64'd1);
    step();
    step();
    req_valid = '0;
    rst       = 1'b0;

    // Single op from r1, latency and busy
    set_op(1, 3, 5, OPM_MULT, 1'b1);
    expect_rsp(1, 15);
    @(negedge clk);
    chk("t1_ready", 64'(req_ready), 64'b0010);
    chk("t1_dsp_a", 64'(dsp_a), 64'd3);
    chk("t1_dsp_b", 64'(dsp_b), 64'd5);
    step();
    clr(1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1_lat_low", 64'(rsp_valid), 64'd0);
      chk("t1_busy_inflight", 64'(busy), 64'd1);
      step();
    end
    @(negedge clk);
    chk("t1_lat_high", 64'(rsp_valid), 64'd1);
    step();
    @(negedge clk);
    chk("t1_busy_after", 64'(busy), 64'd0);
    chk("t1_rsp_gone", 64'(rsp_valid), 64'd0);

    // Bring rr_ptr back to 0 via a single op from r3
    step();
    set_op(3, 1, 1, OPM_MULT, 1'b1);
    expect_rsp(3, 1);
    @(negedge clk);
    chk("t1b_ready", 64'(req_ready), 64'b1000);
    step();
    clr(3);
    drain(20);

    // All four valid: round-robin 0,1,2,3,0
    set_op(0, 1, 2, OPM_MULT, 1'b1);
    set_op(1, 3, 4, OPM_MULT, 1'b1);
    set_op(2, 5, 6, OPM_MULT, 1'b1);
    set_op(3, 7, 8, OPM_MULT, 1'b1);
    expect_rsp(0, 2);
    expect_rsp(1, 12);
    expect_rsp(2, 30);
    expect_rsp(3, 56);
    expect_rsp(0, 90);
    @(negedge clk);
    chk("t2_grant0", 64'(req_ready), 64'b0001);
    step();
    set_op(0, 9, 10, OPM_MULT, 1'b1);
    @(negedge clk);
    chk("t2_grant1", 64'(req_ready), 64'b0010);
    step();
    clr(1);
    @(negedge clk);
    chk("t2_grant2", 64'(req_ready), 64'b0100);
    step();
    clr(2);
    @(negedge clk);
    chk("t2_grant3", 64'(req_ready), 64'b1000);
    step();
    clr(3);
    @(negedge clk);
    chk("t2_grant0_again", 64'(req_ready), 64'b0001);
    step();
    clr(0);
    drain(20);

    // r2 accumulate burst with an idle beat; r0 waits for the lock to drop
    set_op(2, 2, 2, OPM_MULT, 1'b0);
    set_op(0, 6, 7, OPM_MULT, 1'b1);
    expect_rsp(2, 29);
    expect_rsp(0, 42);
    @(negedge clk);
    chk("t3_first", 64'(req_ready), 64'b0100);
    step();
    set_op(2, 3, 3, OPM_ACC, 1'b0);
    @(negedge clk);
    chk("t3_locked", 64'(req_ready), 64'b0100);
    step();
    clr(2);
    @(negedge clk);
    chk("t3_lock_idle", 64'(req_ready), 64'b0100);
    chk("t3_busy", 64'(busy), 64'd1);
    step();
    set_op(2, 4, 4, OPM_ACC, 1'b1);
    @(negedge clk);
    chk("t3_last_beat", 64'(req_ready), 64'b0100);
    step();
    clr(2);
    @(negedge clk);
    chk("t3_r0_after", 64'(req_ready), 64'b0001);
    step();
    clr(0);
    drain(20);

    // Backpressure: result held for 3 cycles, then accept + new issue together
    rsp_ready = 1'b0;
    set_op(1, 11, 13, OPM_MULT, 1'b1);
    expect_rsp(1, 143);
    @(negedge clk);
    chk("t4_ready", 64'(req_ready), 64'b0010);
    step();
    clr(1);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      step();
      @(negedge clk);
      n++;
    end
    chk("t4_rsp_arrive", 64'(rsp_valid), 64'd1);
    chk("t4_stall_ce", 64'(dsp_ce), 64'd0);
    chk("t4_stall_ready", 64'(req_ready), 64'd0);
    chk("t4_stall_p", 64'(rsp_p), 64'd143);
    step();
    set_op(3, 2, 3, OPM_MULT, 1'b1);
    expect_rsp(3, 6);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t4_stall_ce", 64'(dsp_ce), 64'd0);
      chk("t4_stall_ready", 64'(req_ready), 64'd0);
      chk("t4_stall_valid", 64'(rsp_valid), 64'd1);
      chk("t4_stall_p", 64'(rsp_p), 64'd143);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_accept_ce", 64'(dsp_ce), 64'd1);
    chk("t4_issue_with_accept", 64'(req_ready), 64'b1000);
    step();
    clr(3);
    drain(20);

    // Reset in the middle of a locked r2 burst
    set_op(2, 2, 2, OPM_MULT, 1'b0);
    @(negedge clk);
    chk("t5_beat1", 64'(req_ready), 64'b0100);
    step();
    set_op(2, 3, 3, OPM_ACC, 1'b0);
    @(negedge clk);
    chk("t5_beat2", 64'(req_ready), 64'b0100);
    step();
    clr(2);
    @(negedge clk);
    chk("t5_busy_pre", 64'(busy), 64'd1);
    #1;
    rst = 1'b1;
    set_op(0, 5, 5, OPM_MULT, 1'b1);
    set_op(3, 3, 3, OPM_MULT, 1'b1);
    #1;
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t5_rst_ready", 64'(req_ready), 64'd0);
    chk("t5_rst_rsp_id", 64'(rsp_id), 64'd0);
    step();
    rst = 1'b0;
    expect_rsp(0, 25);
    expect_rsp(3, 9);
    @(negedge clk);
    chk("t5_r0_first", 64'(req_ready), 64'b0001);
    step();
    clr(0);
    @(negedge clk);
    chk("t5_r3_next", 64'(req_ready), 64'b1000);
    step();
    clr(3);
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
